// File: rtl/led_pwm_pkg.sv
// Shared constants, channel-index width helper and fade direction type for led_pwm_fader.
// Optional fading is selected with the LED_PWM_FADE_EN macro.
package led_pwm_pkg;

    localparam int unsigned DEF_CH_NUM     = 3;
    localparam int unsigned DEF_PWM_W      = 16;
    localparam int unsigned DEF_FADE_DIV_W = 16;

    // Direction of a single fade step for one channel
    typedef enum logic [1:0] {
        FADE_HOLD = 2'd0,
        FADE_UP   = 2'd1,
        FADE_DOWN = 2'd2
    } fade_dir_e;

    // Width of a channel index; a single channel still needs one bit
    function automatic int unsigned ch_idx_w(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 1) begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: target and current duty, the wrap-synchronised active duty,
// the PWM comparator and (with LED_PWM_FADE_EN) the one-LSB fade step.
module led_pwm_chan
    import led_pwm_pkg::*;
#(
    parameter int unsigned PWM_W = DEF_PWM_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             wrap_i,
    input  logic             fade_step_i,
    input  logic             wr_en_i,
    input  logic [PWM_W-1:0] wr_duty_i,
    input  logic [PWM_W-1:0] cnt_i,
    output logic             led_o,
    output logic             pending_c_o
);

    logic [PWM_W-1:0] target_q, target_d;
    logic [PWM_W-1:0] cur_q,    cur_d;
    logic [PWM_W-1:0] act_q,    act_d;
    logic             led_q,    led_d;

`ifdef LED_PWM_FADE_EN
    fade_dir_e dir_c;

    // Fade direction is judged against the target before any same-cycle write
    always_comb begin
        dir_c = FADE_HOLD;
        if (cur_q < target_q) begin
            dir_c = FADE_UP;
        end else if (cur_q > target_q) begin
            dir_c = FADE_DOWN;
        end
    end
`else
    logic unused_fade_step;
    assign unused_fade_step = fade_step_i;
`endif

    // Next-state for target/current/active duty and the PWM compare
    always_comb begin
        target_d = target_q;
        cur_d    = cur_q;
        act_d    = act_q;
        led_d    = enable_i && (cnt_i < act_q);
`ifdef LED_PWM_FADE_EN
        if (fade_step_i) begin
            case (dir_c)
                FADE_UP:   cur_d = cur_q + PWM_W'(1);
                FADE_DOWN: cur_d = cur_q - PWM_W'(1);
                default:   cur_d = cur_q;
            endcase
        end
        if (wr_en_i) begin
            target_d = wr_duty_i;
        end
`else
        if (wr_en_i) begin
            target_d = wr_duty_i;
            cur_d    = wr_duty_i;
        end
`endif
        if (wrap_i) begin
            act_d = cur_d;
        end
    end

    // Channel state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            target_q <= '0;
            cur_q    <= '0;
            act_q    <= '0;
            led_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            cur_q    <= cur_d;
            act_q    <= act_d;
            led_q    <= led_d;
        end
    end

    assign led_o       = led_q;
    assign pending_c_o = (cur_d != target_d);

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM with glitch-free duty updates and optional fading.
// Define LED_PWM_FADE_EN to enable the fade prescaler and per-channel ramping;
// otherwise writes take effect at the next PWM wrap and fade_div is ignored.
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int unsigned CH_NUM     = DEF_CH_NUM,
    parameter int unsigned PWM_W      = DEF_PWM_W,
    parameter int unsigned FADE_DIV_W = DEF_FADE_DIV_W
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        enable,
    input  logic [PWM_W-1:0]            period,
    input  logic [FADE_DIV_W-1:0]       fade_div,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ch_idx_w(CH_NUM)-1:0] wr_ch,
    input  logic [PWM_W-1:0]            wr_duty,
    output logic [CH_NUM-1:0]           LEDs,
    output logic                        period_tick,
    output logic                        busy
);

    localparam int unsigned CH_W = ch_idx_w(CH_NUM);

    logic [PWM_W-1:0]  cnt_q, cnt_d;
    logic              wrap_c;
    logic              accept_c;
    logic              fade_step_c;
    logic              tick_q;
    logic              busy_q, busy_d;
    logic              rdy_pre_q;
    logic              rdy_q;
    logic [CH_NUM-1:0] wr_en_c;
    logic [CH_NUM-1:0] pending_c;
    logic [CH_NUM-1:0] led_c;

    // Shared PWM counter; wraps after reaching (or passing) period
    always_comb begin
        wrap_c = enable && (cnt_q >= period);
        cnt_d  = cnt_q + PWM_W'(1);
        if (!enable || wrap_c) begin
            cnt_d = '0;
        end
    end

`ifdef LED_PWM_FADE_EN
    logic [FADE_DIV_W-1:0] presc_q, presc_d;

    // Fade prescaler counts PWM wraps and fires a step every fade_div+1 of them
    always_comb begin
        presc_d     = presc_q;
        fade_step_c = 1'b0;
        if (wrap_c) begin
            if (presc_q >= fade_div) begin
                presc_d     = '0;
                fade_step_c = 1'b1;
            end else begin
                presc_d = presc_q + FADE_DIV_W'(1);
            end
        end
    end

    // Prescaler register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic unused_fade_div;
    assign unused_fade_div = ^fade_div;
    assign fade_step_c     = 1'b0;
`endif

    assign accept_c = wr_valid && rdy_q;

    // Decode an accepted write to a one-hot channel enable; out-of-range indices match nothing
    always_comb begin
        wr_en_c = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (accept_c && (wr_ch == CH_W'(i))) begin
                wr_en_c[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        led_pwm_chan #(
            .PWM_W (PWM_W)
        ) u_chan (
            .clk_i       (CLK),
            .rst_ni      (nRST),
            .enable_i    (enable),
            .wrap_i      (wrap_c),
            .fade_step_i (fade_step_c),
            .wr_en_i     (wr_en_c[g]),
            .wr_duty_i   (wr_duty),
            .cnt_i       (cnt_q),
            .led_o       (led_c[g]),
            .pending_c_o (pending_c[g])
        );
    end

    assign busy_d = |pending_c;

    // Counter, status outputs and the two-stage ready delay out of reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            rdy_pre_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tick_q    <= wrap_c;
            busy_q    <= busy_d;
            rdy_pre_q <= 1'b1;
            rdy_q     <= rdy_pre_q;
        end
    end

    assign LEDs        = led_c;
    assign period_tick = tick_q;
    assign busy        = busy_q;
    assign wr_ready    = rdy_q;

endmodule
